// File: rtl/euler_row_stepper.sv
// euler_row_stepper: sequences one explicit Euler update x[i] += f[i] >>> H_SHIFT
// over n_rows memory entries. It emits the step_start / row_end / data_ready
// strobes, in that order, once per step.
module euler_row_stepper #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 5,
  parameter int H_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_async_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_rows,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] x_rd_data,
  input  logic [DATA_W-1:0] f_rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              step_start,
  output logic              row_end,
  output logic              data_ready,
  output logic              sat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_ROWEND,
    S_READY
  } state_e;

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   n_rows_q, n_rows_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                sat_q, sat_d;

  logic signed [DATA_W-1:0] delta;
  logic signed [DATA_W:0]   sum_ext;
  logic                     ovf_pos;
  logic                     ovf_neg;
  logic [DATA_W-1:0]        clamped;
  logic                     last_row;

  // Datapath: floor-shifted derivative added to x one bit wider, then clamped
  always_comb begin
    delta   = $signed(f_rd_data) >>> H_SHIFT;
    sum_ext = {x_rd_data[DATA_W-1], x_rd_data} + {delta[DATA_W-1], delta};
    // The two top bits of the widened sum disagree only when the result
    // does not fit in DATA_W bits; the top bit gives the true sign.
    ovf_pos = ~sum_ext[DATA_W] &  sum_ext[DATA_W-1];
    ovf_neg =  sum_ext[DATA_W] & ~sum_ext[DATA_W-1];
    if (ovf_pos) begin
      clamped = MAX_POS;
    end else if (ovf_neg) begin
      clamped = MAX_NEG;
    end else begin
      clamped = sum_ext[DATA_W-1:0];
    end
  end

  // n_rows_q is at least 1 whenever this is consulted (zero rows skip READ/WRITE)
  assign last_row = (idx_q == n_rows_q - ADDR_W'(1));

  // Next-state and register-update logic for the step sequencer
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d  = state_q;
    idx_d    = idx_q;
    n_rows_d = n_rows_q;
    result_d = result_q;
    sat_d    = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_rows_d = n_rows;
          idx_d    = '0;
          sat_d    = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        state_d = (n_rows_q == '0) ? S_ROWEND : S_READ;
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        result_d = clamped;
        if (ovf_pos || ovf_neg) begin
          sat_d = 1'b1;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (last_row) begin
          state_d = S_ROWEND;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_READ;
        end
      end
      S_ROWEND: begin
        state_d = S_READY;
      end
      S_READY: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      // NOTE: the reset clears result_q too so wr_data reads 0 during reset.
      state_q  <= S_IDLE;
      idx_q    <= '0;
      n_rows_q <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_rows_q <= n_rows_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  // Moore output decode: registered state only, no input-to-output path
  assign busy       = (state_q != S_IDLE);
  assign rd_en      = (state_q == S_READ);
  assign rd_addr    = rd_en ? idx_q : '0;
  assign wr_en      = (state_q == S_WRITE);
  assign wr_addr    = wr_en ? idx_q : '0;
  assign wr_data    = wr_en ? result_q : '0;
  assign step_start = (state_q == S_START);
  assign row_end    = (state_q == S_ROWEND);
  assign data_ready = (state_q == S_READY);
  assign sat        = sat_q;

endmodule

// File: tb/tb_euler_row_stepper.sv
// Self-checking bench for euler_row_stepper: a memory responder plus an
// arithmetic reference model of the Euler update and the strobe timing.
module tb_euler_row_stepper;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 5;
  localparam int H_SHIFT = 4;
  localparam int H_DIV   = 2 ** H_SHIFT;
  localparam int BUDGET  = 400;

  logic              clk = 1'b0;
  logic              rst_async_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] n_rows = '0;
  logic              busy, rd_en, wr_en, step_start, row_end, data_ready, sat;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] x_rd_data = '0;
  logic [DATA_W-1:0] f_rd_data = '0;
  logic [DATA_W-1:0] wr_data;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] x_mem [32];
  logic [DATA_W-1:0] f_mem [32];

  // observations from the latest step
  int  obs_ss_cyc, obs_re_cyc, obs_dr_cyc;
  int  obs_ss_cnt, obs_re_cnt, obs_dr_cnt, obs_rd_cnt, obs_wr_cnt;
  int  obs_clash, obs_busy_gap;
  bit  obs_done, obs_sat;
  logic [ADDR_W-1:0] obs_wa[$];
  logic [DATA_W-1:0] obs_wd[$];

  // model expectations
  logic [DATA_W-1:0] exp_wd[$];
  bit                exp_sat;

  euler_row_stepper #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .H_SHIFT(H_SHIFT)) dut (
    .clk        (clk),
    .rst_async_n(rst_async_n),
    .start      (start),
    .n_rows     (n_rows),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .x_rd_data  (x_rd_data),
    .f_rd_data  (f_rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .step_start (step_start),
    .row_end    (row_end),
    .data_ready (data_ready),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  // Memory: data valid the cycle after rd_en. Writes are captured by the
  // bench monitor rather than applied, since each step reads every row once.
  always @(posedge clk) begin
    if (rd_en) begin
      x_rd_data <= x_mem[rd_addr];
      f_rd_data <= f_mem[rd_addr];
    end
  end

  // Reference Euler update in plain integer arithmetic
  function automatic logic [DATA_W-1:0] ref_euler(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] f,
                                                  output bit ov);
    int xi, fi, d, s;
    xi = $signed(x);
    fi = $signed(f);
    d  = (fi >= 0) ? fi / H_DIV : -((-fi + H_DIV - 1) / H_DIV);
    s  = xi + d;
    ov = 1'b0;
    if (s > 32767) begin
      s = 32767; ov = 1'b1;
    end else if (s < -32768) begin
      s = -32768; ov = 1'b1;
    end
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [32:0] all_outs();
    return {busy, rd_en, rd_addr, wr_en, wr_addr, wr_data,
            step_start, row_end, data_ready, sat};
  endfunction

  function automatic logic [DATA_W-1:0] rand_word(input bit big);
    case ($urandom_range(0, 3))
      0:       return 16'h7FF0 + 16'($urandom_range(0, 15));
      1:       return 16'h8000 + 16'($urandom_range(0, 15));
      2:       return big ? 16'($urandom_range(0, 16'h0FFF)) : 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic compute_expected(input int n);
    bit ov;
    exp_wd.delete();
    exp_sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_wd.push_back(ref_euler(x_mem[i], f_mem[i], ov));
      if (ov) exp_sat = 1'b1;
    end
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) begin
      x_mem[i] = rand_word(1'b0);
      f_mem[i] = rand_word(1'b1);
    end
    compute_expected(n);
  endtask

  // number of write entries that disagree with the model (address or data)
  function automatic int write_errs();
    int e = 0;
    if (obs_wd.size() != exp_wd.size()) e++;
    for (int i = 0; i < obs_wd.size() && i < exp_wd.size(); i++) begin
      if (obs_wa[i] !== ADDR_W'(i) || obs_wd[i] !== exp_wd[i]) e++;
    end
    return e;
  endfunction

  // Issue one start and monitor until data_ready (or the write count stop_wr).
  // Cycle c is the period following the c-th edge after start is sampled.
  task automatic run_step(input int n, input bit hold, input bit repulse, input int stop_wr);
    obs_ss_cyc = -1; obs_re_cyc = -1; obs_dr_cyc = -1;
    obs_ss_cnt = 0; obs_re_cnt = 0; obs_dr_cnt = 0; obs_rd_cnt = 0; obs_wr_cnt = 0;
    obs_clash = 0; obs_busy_gap = 0; obs_done = 1'b0; obs_sat = 1'b0;
    obs_wa.delete(); obs_wd.delete();
    @(negedge clk);
    n_rows = ADDR_W'(n);
    start  = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) start = 1'b0;
      if (!busy) obs_busy_gap++;
      if (step_start) begin obs_ss_cnt++; if (obs_ss_cyc < 0) obs_ss_cyc = c; end
      if (row_end)    begin obs_re_cnt++; if (obs_re_cyc < 0) obs_re_cyc = c; end
      if (data_ready) begin obs_dr_cnt++; if (obs_dr_cyc < 0) obs_dr_cyc = c; end
      if (rd_en) obs_rd_cnt++;
      if (wr_en) begin
        obs_wr_cnt++;
        obs_wa.push_back(wr_addr);
        obs_wd.push_back(wr_data);
      end
      if (rd_en && wr_en) obs_clash++;
      if (int'(step_start) + int'(row_end) + int'(data_ready) > 1) obs_clash++;
      if (repulse) begin
        start  = (c == 2 || c == 3);
        n_rows = ADDR_W'($urandom);
      end
      if (data_ready || (stop_wr > 0 && obs_wr_cnt == stop_wr)) begin
        obs_sat  = sat;
        obs_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    n_rows = 5'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_outs() !== 33'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", all_outs());
    end
    start = 1'b0;
    rst_async_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b exp 0", busy); end
    x_mem[0] = 16'h1234; f_mem[0] = 16'h0020;
    compute_expected(1);
    run_step(1, 1'b0, 1'b0, 0);
    checks++;
    if (obs_ss_cyc !== 1) begin errors++; $display("FAIL reset_first_step_start got %0d exp 1", obs_ss_cyc); end
    checks++;
    if (write_errs() !== 0) begin errors++; $display("FAIL reset_first_write got %0d bad exp 0", write_errs()); end
  endtask

  task automatic test_three_rows();
    x_mem[0] = 16'h0100; f_mem[0] = 16'h0040;
    x_mem[1] = 16'h0010; f_mem[1] = 16'hFFE0;
    x_mem[2] = 16'h0005; f_mem[2] = 16'hFFFF;
    exp_wd.delete();
    exp_wd.push_back(16'h0104); exp_wd.push_back(16'h000E); exp_wd.push_back(16'h0004);
    run_step(3, 1'b0, 1'b0, 0);
    checks++;
    if (obs_done !== 1'b1) begin errors++; $display("FAIL three_timeout got %b exp 1", obs_done); end
    checks++;
    if (write_errs() !== 0) begin errors++; $display("FAIL three_writes got %0d bad exp 0", write_errs()); end
    checks++;
    if (obs_re_cyc !== 11) begin errors++; $display("FAIL three_row_end_cycle got %0d exp 11", obs_re_cyc); end
    checks++;
    if (obs_dr_cyc !== 12) begin errors++; $display("FAIL three_data_ready_cycle got %0d exp 12", obs_dr_cyc); end
    checks++;
    if (obs_sat !== 1'b0) begin errors++; $display("FAIL three_sat got %b exp 0", obs_sat); end
    checks++;
    if (obs_busy_gap !== 0 || obs_clash !== 0 || obs_rd_cnt !== 3) begin
      errors++;
      $display("FAIL three_busy_clash_reads got gap=%0d clash=%0d rd=%0d exp 0 0 3",
               obs_busy_gap, obs_clash, obs_rd_cnt);
    end
  endtask

  task automatic test_saturation();
    x_mem[0] = 16'h7FF0; f_mem[0] = 16'h0400;
    x_mem[1] = 16'h8005; f_mem[1] = 16'hF000;
    compute_expected(2);
    run_step(2, 1'b0, 1'b0, 0);
    checks++;
    if (write_errs() !== 0 || obs_wd.size() != 2) begin
      errors++; $display("FAIL sat_writes got %0d bad exp 0", write_errs());
    end else begin
      checks++;
      if (obs_wd[0] !== 16'h7FFF || obs_wd[1] !== 16'h8000) begin
        errors++; $display("FAIL sat_clamp_values got %h %h exp 7fff 8000", obs_wd[0], obs_wd[1]);
      end
    end
    checks++;
    if (obs_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %b exp 1", obs_sat); end
    repeat (3) @(negedge clk);
    checks++;
    if (sat !== 1'b1) begin errors++; $display("FAIL sat_sticky_idle got %b exp 1", sat); end
    x_mem[0] = 16'h0001; f_mem[0] = 16'h0001;
    compute_expected(1);
    run_step(1, 1'b0, 1'b0, 0);
    checks++;
    if (obs_sat !== 1'b0 || write_errs() !== 0) begin
      errors++; $display("FAIL sat_cleared_by_start got sat=%b bad=%0d exp 0 0", obs_sat, write_errs());
    end
  endtask

  task automatic test_zero_rows();
    exp_wd.delete();
    run_step(0, 1'b0, 1'b0, 0);
    checks++;
    if (obs_ss_cyc !== 1 || obs_re_cyc !== 2 || obs_dr_cyc !== 3) begin
      errors++; $display("FAIL zero_strobe_cycles got %0d %0d %0d exp 1 2 3", obs_ss_cyc, obs_re_cyc, obs_dr_cyc);
    end
    checks++;
    if (obs_rd_cnt !== 0 || obs_wr_cnt !== 0) begin
      errors++; $display("FAIL zero_no_access got rd=%0d wr=%0d exp 0 0", obs_rd_cnt, obs_wr_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    int stray;
    load_random(2);
    run_step(2, 1'b0, 1'b1, 0);
    start = 1'b0;
    checks++;
    if (obs_wr_cnt !== 2 || write_errs() !== 0) begin
      errors++; $display("FAIL busy_writes got wr=%0d bad=%0d exp 2 0", obs_wr_cnt, write_errs());
    end
    checks++;
    if (obs_dr_cnt !== 1 || obs_ss_cnt !== 1 || obs_dr_cyc !== 9) begin
      errors++; $display("FAIL busy_strobes got ss=%0d dr=%0d dr_cyc=%0d exp 1 1 9", obs_ss_cnt, obs_dr_cnt, obs_dr_cyc);
    end
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy || step_start || data_ready) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL busy_no_retrigger got %0d active cycles exp 0", stray); end
  endtask

  task automatic test_back_to_back();
    int ss_at;
    bit idle_seen;
    x_mem[0] = 16'h0200; f_mem[0] = 16'h0100;
    compute_expected(1);
    run_step(1, 1'b1, 1'b0, 0);
    checks++;
    if (obs_dr_cyc !== 6) begin errors++; $display("FAIL b2b_first_ready got %0d exp 6", obs_dr_cyc); end
    ss_at = -1;
    idle_seen = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1 && !busy) idle_seen = 1'b1;
      if (step_start && ss_at < 0) begin ss_at = k; start = 1'b0; end
    end
    start = 1'b0;
    checks++;
    if (ss_at !== 2 || !idle_seen) begin
      errors++; $display("FAIL b2b_restart got ss_offset=%0d idle=%b exp 2 1", ss_at, idle_seen);
    end
    ss_at = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (data_ready) begin ss_at = k; break; end
    end
    checks++;
    if (ss_at < 0) begin errors++; $display("FAIL b2b_second_ready got none exp pulse"); end
  endtask

  task automatic test_reset_mid();
    int late;
    load_random(4);
    run_step(4, 1'b0, 1'b0, 2);
    checks++;
    if (obs_wr_cnt !== 2 || !wr_en) begin
      errors++; $display("FAIL mid_reach_second_write got wr=%0d en=%b exp 2 1", obs_wr_cnt, wr_en);
    end
    #2 rst_async_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 33'd0) begin errors++; $display("FAIL mid_async_drop got %h exp 0", all_outs()); end
    late = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (row_end || data_ready || rd_en || wr_en || step_start) late++;
    end
    checks++;
    if (late !== 0) begin errors++; $display("FAIL mid_no_strobes got %0d exp 0", late); end
    rst_async_n = 1'b1;
    load_random(4);
    run_step(4, 1'b0, 1'b0, 0);
    checks++;
    if (write_errs() !== 0 || obs_dr_cyc !== 15 || obs_re_cyc !== 14 || obs_sat !== exp_sat) begin
      errors++;
      $display("FAIL mid_recovery_step got bad=%0d re=%0d dr=%0d sat=%b exp 0 14 15 %b",
               write_errs(), obs_re_cyc, obs_dr_cyc, obs_sat, exp_sat);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 12);
      load_random(n);
      run_step(n, 1'b0, 1'b0, 0);
      checks++;
      if (write_errs() !== 0 || obs_rd_cnt !== n) begin
        errors++; $display("FAIL rand_writes it=%0d n=%0d got bad=%0d rd=%0d exp 0 %0d", it, n, write_errs(), obs_rd_cnt, n);
      end
      checks++;
      if (obs_ss_cyc !== 1 || obs_re_cyc !== 2 + 3 * n || obs_dr_cyc !== 3 + 3 * n) begin
        errors++;
        $display("FAIL rand_timing it=%0d got %0d %0d %0d exp 1 %0d %0d", it, obs_ss_cyc, obs_re_cyc, obs_dr_cyc, 2 + 3 * n, 3 + 3 * n);
      end
      checks++;
      if (obs_sat !== exp_sat || obs_clash !== 0 || obs_busy_gap !== 0) begin
        errors++;
        $display("FAIL rand_flags it=%0d got sat=%b clash=%0d gap=%0d exp %b 0 0", it, obs_sat, obs_clash, obs_busy_gap, exp_sat);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = '0;
      f_mem[i] = '0;
    end
    test_reset();
    test_three_rows();
    test_saturation();
    test_zero_rows();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/euler_row_stepper.md
Name: euler_row_stepper

Overview:
- Upstream sequencing stage of the Euler step. It performs one explicit Euler update, x[i] <= x[i] + h*f[i] with h = 2^-H_SHIFT, over n_rows entries of the state/derivative memories.
- It produces the three strobes consumed by the end-of-Euler detector:
  - step_start, which feeds F;
  - row_end, which feeds R;
  - data_ready, which feeds D.
- These strobes are emitted strictly in the order F, then R, then D, once per step.

Parameters:
- DATA_W, 16: width of x and f words, signed two's complement.
- ADDR_W, 5: row address width; maximum 2^ADDR_W - 1 rows.
- H_SHIFT, 4: step size exponent; h = 2^-H_SHIFT.

Ports:
- clk  in  1  rising-edge clock
- rst_async_n  in  1  asynchronous active-low reset
- start  in  1  request one Euler step; sampled only in IDLE
- n_rows  in  ADDR_W  row count; latched on accepted start
- busy  out  1  high whenever state != IDLE
- rd_en  out  1  read strobe to x and f memories
- rd_addr  out  ADDR_W  read address
- x_rd_data  in  DATA_W  x[rd_addr], valid in the cycle after rd_en
- f_rd_data  in  DATA_W  f[rd_addr], valid in the cycle after rd_en
- wr_en  out  1  write strobe to x memory
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  updated x value
- step_start  out  1  one-cycle pulse; feeds F
- row_end  out  1  one-cycle pulse after last row written; feeds R
- data_ready  out  1  one-cycle pulse, final strobe; feeds D
- sat  out  1  sticky overflow flag for the current step

Behaviour:
- Reset: asynchronous, active-low. It forces state = IDLE and clears idx, the latched n_rows and sat. All outputs read 0 while rst_async_n is low.
- Reset asserted mid-step: operation aborts immediately. No further rd_en, wr_en or strobes are issued. A write already in progress in that cycle is not guaranteed.
- Output timing: all outputs are Moore, decoded from registered state, idx and the datapath register. There is no combinational path from any input to any output.
- States and transitions:
  - IDLE: if start=1, latch n_rows, set idx=0, clear sat, go to START. Otherwise stay.
  - START: step_start=1. If latched n_rows==0, go to ROWEND; else go to READ.
  - READ: rd_en=1, rd_addr=idx. Go to WAIT.
  - WAIT: capture x_rd_data and f_rd_data and compute the result into the write register. Go to WRITE.
  - WRITE: wr_en=1, wr_addr=idx, wr_data=result. If idx == n_rows-1, go to ROWEND; else idx <= idx+1 and go to READ.
  - ROWEND: row_end=1. Go to READY.
  - READY: data_ready=1. Go to IDLE.
- Latency: start sampled at edge k gives:
  - step_start high in cycle k+1;
  - each row takes 3 cycles (READ, WAIT, WRITE);
  - row_end high in cycle k+2+3n;
  - data_ready high in cycle k+3+3n;
  - busy high from cycle k+1 through k+3+3n inclusive.
- Start handling: start is ignored in every state other than IDLE. n_rows changes while busy have no effect.
- Back-to-back steps: start held high continuously re-triggers on the cycle after READY, because IDLE is entered and sampled normally.
- Arithmetic:
  - delta = f >>> H_SHIFT, an arithmetic shift that floors toward -inf, so f = -1 gives delta = -1.
  - sum = sign-extended x + sign-extended delta, computed at DATA_W+1 bits.
  - On positive overflow, clamp to 2^(DATA_W-1)-1; on negative overflow, clamp to -2^(DATA_W-1). In either case set sat.
  - sat stays set until the next accepted start.
- Strobes: step_start, row_end and data_ready are each exactly one cycle wide and mutually exclusive. rd_en and wr_en are never asserted in the same cycle.

Test Plan:
- Reset: hold rst_async_n=0 with start=1 -> all outputs 0 and busy=0. Release, then pulse start with n_rows=1 -> step_start appears 1 cycle after start is sampled.
- Three-row step, H_SHIFT=4, start sampled at edge 0. Memory contents x={0x0100,0x0010,0x0005}, f={0x0040,0xFFE0,0xFFFF} -> writes 0x0104 @0, 0x000E @1, 0x0004 @2. row_end in cycle 11, data_ready in cycle 12, sat=0.
- Saturation: x=0x7FF0, f=0x0400 -> wr_data=0x7FFF, sat=1. Then x=0x8005, f=0xF000 -> wr_data=0x8000. sat stays 1 until the next start, which clears it.
- Zero rows: n_rows=0 -> step_start, row_end and data_ready pulse on 3 consecutive cycles. No rd_en or wr_en is asserted.
- Start while busy: n_rows=2, with start re-pulsed during READ and WAIT -> ignored. Exactly 2 writes occur and one data_ready pulse. A start held high continuously gives a new step_start 2 cycles after data_ready.
- Reset mid-step: n_rows=4, assert rst_async_n=0 during the second WRITE -> outputs drop to 0 asynchronously and no row_end or data_ready appears. After release, a new start runs a normal 4-row step.
